// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbiter.
// Optional build macro used by the arbiter: ASYNC_FIFO_WR_ARB_PRIO0_EN.
package async_fifo_pkg;

    // Arbiter FSM states: searching for a winner, or moving a locked burst.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Legal range of beats a single grant may carry.
    localparam int BURST_MAX_MIN = 1;
    localparam int BURST_MAX_MAX = 256;

    // Width of an index into n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after ptr+1 (mod NREQ).
module async_fifo_rr_pick
    import async_fifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [IDW-1:0] idx_s;
        found  = 1'b0;
        winner = '0;
        idx_s  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx_s  = IDW'((int'(ptr) + i) % NREQ);
            found  = found | req[idx_s];
            winner = req[idx_s] ? idx_s : winner;
        end
    end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Write-side arbiter: shares one async FIFO write port between NREQ
// valid/ready requesters with round-robin grants and burst lock.
// Optional macro ASYNC_FIFO_WR_ARB_PRIO0_EN gives requester 0 absolute priority.
module async_fifo_wr_arb
    import async_fifo_pkg::*;
#(
    parameter int DW        = 32,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 8,
    localparam int IDW      = id_width(NREQ)
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_rdy,
    input  logic                 wr_full,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    output logic [IDW-1:0]       wr_id,
    output logic                 arb_busy
);

    localparam int CNTW = id_width(BURST_MAX);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BURST_MAX - 1);

    arb_state_t      state_r, state_nxt_s;
    logic [IDW-1:0]  grant_r, grant_nxt_s;
    logic [IDW-1:0]  rr_ptr_r, rr_ptr_nxt_s;
    logic [CNTW-1:0] beat_cnt_r, beat_cnt_nxt_s;
    logic            found_s;
    logic [IDW-1:0]  winner_s;
    logic            beat_s;

    async_fifo_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req_vld),
        .ptr    (rr_ptr_r),
        .found  (found_s),
        .winner (winner_s)
    );

    // State, grant, round-robin pointer and beat counter registers.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_r    <= ARB;
            grant_r    <= '0;
            rr_ptr_r   <= IDW'(NREQ - 1);
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Next-state logic and the combinational write-port handshake.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        beat_cnt_nxt_s = beat_cnt_r;
        req_rdy        = '0;
        wr_en          = 1'b0;
        arb_busy       = 1'b0;
        beat_s         = 1'b0;
        wr_id          = grant_r;
        wr_data        = req_data[int'(grant_r)*DW +: DW];
        case (state_r)
            ARB: begin
`ifdef ASYNC_FIFO_WR_ARB_PRIO0_EN
                // Requester 0 pre-empts the rotation and leaves rr_ptr alone.
                if (req_vld[0]) begin
                    grant_nxt_s    = '0;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = XFER;
                end else if (found_s) begin
                    grant_nxt_s    = winner_s;
                    rr_ptr_nxt_s   = winner_s;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = XFER;
                end else begin
                    state_nxt_s    = ARB;
                end
`else
                if (found_s) begin
                    grant_nxt_s    = winner_s;
                    rr_ptr_nxt_s   = winner_s;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = XFER;
                end else begin
                    state_nxt_s    = ARB;
                end
`endif
            end
            XFER: begin
                arb_busy         = 1'b1;
                req_rdy[grant_r] = ~wr_full;
                beat_s           = req_vld[grant_r] & ~wr_full;
                wr_en            = beat_s;
                // Grant is held while the owner idles or the FIFO is full.
                if (beat_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + CNTW'(1);
                    if (req_last[grant_r] || (beat_cnt_r == LAST_BEAT)) begin
                        state_nxt_s = ARB;
                    end else begin
                        state_nxt_s = XFER;
                    end
                end else begin
                    state_nxt_s = XFER;
                end
            end
            default: begin
                state_nxt_s = ARB;
            end
        endcase
    end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed self-checking bench for async_fifo_wr_arb (DW=32, NREQ=4, BURST_MAX=8).
module tb_async_fifo_wr_arb;

    localparam int DW   = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                wr_clk = 1'b0;
    logic                wr_rst = 1'b1;
    logic [NREQ-1:0]     req_vld = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_last = '0;
    logic [NREQ-1:0]     req_rdy;
    logic                wr_full = 1'b0;
    logic                wr_en;
    logic [DW-1:0]       wr_data;
    logic [IDW-1:0]      wr_id;
    logic                arb_busy;

    int errors = 0;
    int checks = 0;

    async_fifo_wr_arb #(.DW(DW), .NREQ(NREQ), .BURST_MAX(8)) dut (
        .wr_clk   (wr_clk),
        .wr_rst   (wr_rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .wr_full  (wr_full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_id    (wr_id),
        .arb_busy (arb_busy)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst   = 1'b1;
        req_vld  = '0;
        req_last = '0;
        wr_full  = 1'b0;
        cyc();
        wr_rst   = 1'b0;
    endtask

    initial begin
        logic [IDW-1:0] order2 [5];
        logic [IDW-1:0] order6 [4];
        order2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef ASYNC_FIFO_WR_ARB_PRIO0_EN
        order6 = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        order6 = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif

        // Reset state.
        cyc();
        #1;
        chk("rst_rdy", 32'(req_rdy), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_busy", 32'(arb_busy), 32'h0);

        // Single requester, 3-beat burst ending with last.
        wr_rst = 1'b0;
        req_vld = 4'b0001;
        req_data[0*DW +: DW] = 32'hA000_0000;
        #1;
        chk("t1_arb_rdy", 32'(req_rdy), 32'h0);
        chk("t1_arb_busy", 32'(arb_busy), 32'h0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            req_data[0*DW +: DW] = 32'hA000_0000 + 32'(k);
            req_last = (k == 2) ? 4'b0001 : 4'b0000;
            #1;
            chk("t1_rdy", 32'(req_rdy), 32'h1);
            chk("t1_wr_en", 32'(wr_en), 32'h1);
            chk("t1_wr_id", 32'(wr_id), 32'h0);
            chk("t1_wr_data", wr_data, 32'hA000_0000 + 32'(k));
            cyc();
        end
        req_vld = '0;
        req_last = '0;
        #1;
        chk("t1_back_arb", 32'(arb_busy), 32'h0);
        chk("t1_back_wr_en", 32'(wr_en), 32'h0);

        // All four valid, 2-beat bursts: rotation 0,1,2,3,0.
        do_reset();
        req_vld = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            req_last = 4'b0000;
            #1;
            chk("t2_arb_wr_en", 32'(wr_en), 32'h0);
            cyc();
            #1;
            chk("t2_b1_wr_en", 32'(wr_en), 32'h1);
            chk("t2_b1_id", 32'(wr_id), 32'(order2[b]));
            cyc();
            req_last = 4'b1111;
            #1;
            chk("t2_b2_wr_en", 32'(wr_en), 32'h1);
            chk("t2_b2_id", 32'(wr_id), 32'(order2[b]));
            cyc();
        end

        // Requester 2 streams without last: cut at 8 beats, others served first.
        do_reset();
        req_vld = 4'b0100;
        req_last = 4'b0000;
        #1;
        chk("t3_arb_busy", 32'(arb_busy), 32'h0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            req_vld = 4'b0111;
            req_last = 4'b0011;
            req_data[2*DW +: DW] = 32'hB200_0000 + 32'(k);
            #1;
            chk("t3_wr_en", 32'(wr_en), 32'h1);
            chk("t3_wr_id", 32'(wr_id), 32'h2);
            chk("t3_wr_data", wr_data, 32'hB200_0000 + 32'(k));
            cyc();
        end
        #1;
        chk("t3_release_busy", 32'(arb_busy), 32'h0);
        chk("t3_release_wr_en", 32'(wr_en), 32'h0);
        cyc();
        chk("t3_next_id0", 32'(wr_id), 32'h0);
        chk("t3_next_en0", 32'(wr_en), 32'h1);
        cyc();
        chk("t3_gap_busy", 32'(arb_busy), 32'h0);
        cyc();
        chk("t3_next_id1", 32'(wr_id), 32'h1);
        cyc();
        chk("t3_gap2_busy", 32'(arb_busy), 32'h0);
        cyc();
        chk("t3_regrant_id2", 32'(wr_id), 32'h2);
        chk("t3_regrant_en", 32'(wr_en), 32'h1);

        // FIFO full for 5 cycles mid-burst; beat count and data order preserved.
        do_reset();
        req_vld = 4'b0001;
        cyc();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                wr_full = 1'b1;
                req_data[0*DW +: DW] = 32'hC000_0002;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("t4_full_wr_en", 32'(wr_en), 32'h0);
                    chk("t4_full_rdy", 32'(req_rdy), 32'h0);
                    chk("t4_full_busy", 32'(arb_busy), 32'h1);
                    cyc();
                end
                wr_full = 1'b0;
            end
            req_data[0*DW +: DW] = 32'hC000_0000 + 32'(k);
            #1;
            chk("t4_wr_en", 32'(wr_en), 32'h1);
            chk("t4_wr_data", wr_data, 32'hC000_0000 + 32'(k));
            cyc();
        end
        req_vld = '0;
        #1;
        chk("t4_done_busy", 32'(arb_busy), 32'h0);

        // Reset during beat 3 of a burst from requester 1.
        do_reset();
        req_vld = 4'b0010;
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_wr_id", 32'(wr_id), 32'h1);
            chk("t5_wr_en", 32'(wr_en), 32'h1);
            if (k == 2) wr_rst = 1'b1;
            cyc();
        end
        chk("t5_rst_rdy", 32'(req_rdy), 32'h0);
        chk("t5_rst_wr_en", 32'(wr_en), 32'h0);
        chk("t5_rst_busy", 32'(arb_busy), 32'h0);
        wr_rst = 1'b0;
        req_vld = 4'b0011;
        req_last = 4'b0011;
        #1;
        chk("t5_arb_busy", 32'(arb_busy), 32'h0);
        cyc();
        chk("t5_first_id0", 32'(wr_id), 32'h0);
        chk("t5_first_en", 32'(wr_en), 32'h1);
        cyc();

        // Requesters 0 and 1 held valid with single-beat bursts.
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("t6_arb_wr_en", 32'(wr_en), 32'h0);
            cyc();
            chk("t6_wr_id", 32'(wr_id), 32'(order6[b]));
            chk("t6_wr_en", 32'(wr_en), 32'h1);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
